rv_fifo_ctrl: RTL and testbench

//  Ready/valid FIFO controller that drives an external dual-port RAM instance.

---
 rtl/rv_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_rv_fifo_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rv_fifo_ctrl.sv
// Ready/valid FIFO controller driving an external dual-port RAM (sync write, comb read).
// Optional occupancy high-water mark output enabled by defining RV_FIFO_STATS_EN.
module rv_fifo_ctrl #(
  parameter int DATAW    = 8,
  parameter int DEPTH    = 4,
  parameter int ADDRW    = $clog2(DEPTH),
  parameter int ALM_FULL = DEPTH - 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [DATAW-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [DATAW-1:0] pop_data,
  input  logic             pop_ready,
  output logic [ADDRW:0]   count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             ram_wren,
  output logic [ADDRW-1:0] ram_waddr,
  output logic [DATAW-1:0] ram_wdata,
  output logic [ADDRW-1:0] ram_raddr,
  input  logic [DATAW-1:0] ram_rdata
`ifdef RV_FIFO_STATS_EN
  ,
  output logic [ADDRW:0]   peak_count
`endif
);

  localparam logic [ADDRW:0] ALM_FULL_C = (ADDRW+1)'(ALM_FULL);
  localparam logic [ADDRW:0] ONE_C      = (ADDRW+1)'(1);

  logic [ADDRW:0] wr_ptr_r;
  logic [ADDRW:0] rd_ptr_r;
  logic [ADDRW:0] count_r;
  logic [ADDRW:0] wr_ptr_nxt_s;
  logic [ADDRW:0] rd_ptr_nxt_s;
  logic [ADDRW:0] count_nxt_s;
  logic           full_s;
  logic           empty_s;
  logic           push_fire_s;
  logic           pop_fire_s;

  // Flags decoded from registered pointers; the wrap bit distinguishes full from empty.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[ADDRW-1:0] == rd_ptr_r[ADDRW-1:0]) &&
                   (wr_ptr_r[ADDRW] != rd_ptr_r[ADDRW]);

  assign push_fire_s = push_valid & ~full_s;
  assign pop_fire_s  = ~empty_s & pop_ready;

  assign full        = full_s;
  assign empty       = empty_s;
  assign push_ready  = ~full_s;
  assign pop_valid   = ~empty_s;
  assign count       = count_r;
  assign almost_full = (count_r >= ALM_FULL_C);

  assign ram_wren  = push_fire_s & ~flush;
  assign ram_waddr = wr_ptr_r[ADDRW-1:0];
  assign ram_wdata = push_data;
  assign ram_raddr = rd_ptr_r[ADDRW-1:0];
  assign pop_data  = ram_rdata;

  // Next-state pointers and occupancy; flush wins over any handshake in the same cycle.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
      count_nxt_s  = '0;
    end else begin
      if (push_fire_s) begin
        wr_ptr_nxt_s = wr_ptr_r + ONE_C;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_fire_s) begin
        rd_ptr_nxt_s = rd_ptr_r + ONE_C;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_fire_s, pop_fire_s})
        2'b10:   count_nxt_s = count_r + ONE_C;
        2'b01:   count_nxt_s = count_r - ONE_C;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

`ifdef RV_FIFO_STATS_EN
  logic [ADDRW:0] peak_count_r;

  // High-water mark of occupancy, restarted by reset and flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      peak_count_r <= '0;
    end else if (flush) begin
      peak_count_r <= '0;
    end else if (count_nxt_s > peak_count_r) begin
      peak_count_r <= count_nxt_s;
    end else begin
      peak_count_r <= peak_count_r;
    end
  end

  assign peak_count = peak_count_r;
`endif

endmodule

// File: tb/tb_rv_fifo_ctrl.sv
// Directed bench for rv_fifo_ctrl with a behavioural RAM and a scoreboard queue.
// Honours RV_FIFO_STATS_EN to also check peak_count.
module tb_rv_fifo_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic       pop_valid;
  logic [7:0] pop_data;
  logic       pop_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       ram_wren;
  logic [1:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [1:0] ram_raddr;
  logic [7:0] ram_rdata;
`ifdef RV_FIFO_STATS_EN
  logic [2:0] peak_count;
`endif

  rv_fifo_ctrl #(.DATAW(8), .DEPTH(4), .ALM_FULL(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .ram_wren(ram_wren), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
`ifdef RV_FIFO_STATS_EN
    , .peak_count(peak_count)
`endif
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, combinational read.
  logic [7:0] mem [4];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_waddr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_raddr];

  int         n_checks = 0;
  int         n_passed = 0;
  logic [7:0] exp_q[$];
  logic [1:0] wr_idx = 2'd0;
  logic [1:0] rd_idx = 2'd0;
  int         peak_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    wr_idx = 2'd0;
    rd_idx = 2'd0;
    peak_m = 0;
  endtask

  // Compare registered status against the scoreboard occupancy.
  task automatic check_state(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == 4));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 3));
    check({tag, ".push_ready"}, 32'(push_ready), 32'(n != 4));
    check({tag, ".pop_valid"}, 32'(pop_valid), 32'(n != 0));
    if (n != 0) check({tag, ".head"}, 32'(pop_data), 32'(exp_q[0]));
`ifdef RV_FIFO_STATS_EN
    check({tag, ".peak"}, 32'(peak_count), 32'(peak_m));
`endif
  endtask

  // One clock of stimulus at the negedge: check RAM drive, update model, clock, check state.
  task automatic step(input string tag, input logic pv, input logic [7:0] pd,
                      input logic pr, input logic fl, output logic pushed);
    int  n;
    logic push_f;
    logic pop_f;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    flush      = fl;
    #1;
    n      = exp_q.size();
    push_f = pv && (n < 4);
    pop_f  = pr && (n > 0);
    check({tag, ".wren"}, 32'(ram_wren), 32'(push_f && !fl));
    if (push_f && !fl) begin
      check({tag, ".waddr"}, 32'(ram_waddr), 32'(wr_idx));
      check({tag, ".wdata"}, 32'(ram_wdata), 32'(pd));
    end
    if (pop_f) begin
      check({tag, ".raddr"}, 32'(ram_raddr), 32'(rd_idx));
      check({tag, ".pop_data"}, 32'(pop_data), 32'(exp_q[0]));
    end
    if (fl) begin
      model_reset();
    end else begin
      if (pop_f) begin
        void'(exp_q.pop_front());
        rd_idx = rd_idx + 2'd1;
      end
      if (push_f) begin
        exp_q.push_back(pd);
        wr_idx = wr_idx + 2'd1;
      end
      if (exp_q.size() > peak_m) peak_m = exp_q.size();
    end
    pushed = push_f && !fl;
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    logic       pushed;
    int         idx;
    int         budget;
    resetn     = 1'b0;
    flush      = 1'b0;
    push_valid = 1'b0;
    push_data  = 8'h00;
    pop_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_state("reset");
    check("reset.wren", 32'(ram_wren), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: single push, visible next cycle
    step("t1.push", 1'b1, 8'hA1, 1'b0, 1'b0, pushed);
    step("t1.pop", 1'b0, 8'h00, 1'b1, 1'b0, pushed);

    // 2: fill to full, then a rejected 5th push
    for (int i = 0; i < 4; i++) step("t2.fill", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, pushed);
    step("t2.over", 1'b1, 8'h14, 1'b0, 1'b0, pushed);
    check("t2.over_dropped", 32'(pushed), 32'd0);

    // 3: drain while pushing 0x20..0x25 continuously, wrapping the addresses
    idx    = 0;
    budget = 40;
    while ((idx < 6 || exp_q.size() != 0) && budget > 0) begin
      step("t3.stream", idx < 6, 8'h20 + 8'(idx), 1'b1, 1'b0, pushed);
      if (pushed) idx++;
      budget--;
    end
    check("t3.budget", 32'(budget > 0), 32'd1);

    // 4: steady push+pop at count 2
    step("t4.pre", 1'b1, 8'h30, 1'b0, 1'b0, pushed);
    step("t4.pre", 1'b1, 8'h31, 1'b0, 1'b0, pushed);
    for (int i = 0; i < 5; i++) step("t4.pp", 1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, pushed);

    // 5: flush at count 3 with a push offered
    step("t5.pre", 1'b1, 8'h50, 1'b0, 1'b0, pushed);
    step("t5.flush", 1'b1, 8'h51, 1'b0, 1'b1, pushed);

    // 6: async reset mid-cycle at count 2
    step("t6.pre", 1'b1, 8'h60, 1'b0, 1'b0, pushed);
    step("t6.pre", 1'b1, 8'h61, 1'b0, 1'b0, pushed);
    push_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_state("t6.async");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) step("t6.refill", 1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, pushed);
    for (int i = 0; i < 4; i++) step("t6.drain", 1'b0, 8'h00, 1'b1, 1'b0, pushed);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
